// File: rtl/alu_result_skid.sv
// Registered two-entry skid buffer between the ALU and writeback. It applies
// signed-overflow trap suppression and tracks committed flags and a trap count.
module alu_result_skid #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic [TAG_W-1:0]  in_rd,
  input  logic              in_we,
  input  logic              in_trap_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [3:0]        out_flags,
  output logic [TAG_W-1:0]  out_rd,
  output logic              out_we,
  output logic [3:0]        status_flags,
  output logic              ovf_trap,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [1:0]        occupancy
);

  // Entry layout: {r, flags[3:0], rd, we}
  localparam int E_W = DATA_W + 4 + TAG_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) sat_inc = v;
    else                    sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [E_W-1:0]   head_r, skid_r;
  logic             head_valid_r, skid_valid_r;
  logic             in_ready_r;
  logic [3:0]       status_flags_r;
  logic             ovf_trap_r;
  logic [CNT_W-1:0] ovf_count_r;
  logic [1:0]       occupancy_r;

  logic             accept_s, take_s, pop_s, trap_s;
  logic [E_W-1:0]   in_entry_s;
  logic             head_load_in_s, head_load_skid_s, skid_load_s;
  logic             head_valid_nxt_s, skid_valid_nxt_s;

  // Decode handshakes and build the entry to be stored at accept.
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    take_s     = accept_s & ~flush;
    pop_s      = head_valid_r & out_ready;
    trap_s     = take_s & in_trap_en & in_overflow;
    in_entry_s = {in_r, in_zero, in_carry, in_negative, in_overflow, in_rd,
                  in_we & ~(in_trap_en & in_overflow)};
  end

  // Next-state selection for the head/skid pair.
  always_comb begin
    head_load_in_s   = 1'b0;
    head_load_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    head_valid_nxt_s = head_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      head_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else begin
      case ({head_valid_r, skid_valid_r})
        2'b00: begin
          head_load_in_s   = take_s;
          head_valid_nxt_s = take_s;
        end
        2'b10: begin
          if (take_s && pop_s) begin
            head_load_in_s = 1'b1;
          end else if (take_s) begin
            skid_load_s      = 1'b1;
            skid_valid_nxt_s = 1'b1;
          end else if (pop_s) begin
            head_valid_nxt_s = 1'b0;
          end else begin
            head_valid_nxt_s = 1'b1;
          end
        end
        2'b11: begin
          if (pop_s) begin
            head_load_skid_s = 1'b1;
            skid_valid_nxt_s = 1'b0;
          end else begin
            skid_valid_nxt_s = 1'b1;
          end
        end
        default: begin
          head_valid_nxt_s = 1'b0;
          skid_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Storage, handshake and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r         <= {E_W{1'b0}};
      skid_r         <= {E_W{1'b0}};
      head_valid_r   <= 1'b0;
      skid_valid_r   <= 1'b0;
      in_ready_r     <= 1'b1;
      status_flags_r <= 4'b0000;
      ovf_trap_r     <= 1'b0;
      ovf_count_r    <= {CNT_W{1'b0}};
      occupancy_r    <= 2'b00;
    end else begin
      if (head_load_in_s)        head_r <= in_entry_s;
      else if (head_load_skid_s) head_r <= skid_r;
      else                       head_r <= head_r;
      if (skid_load_s) skid_r <= in_entry_s;
      else             skid_r <= skid_r;
      head_valid_r <= head_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
      occupancy_r  <= {1'b0, head_valid_nxt_s} + {1'b0, skid_valid_nxt_s};
      // A pop commits flags even in a flush cycle.
      if (pop_s) status_flags_r <= head_r[TAG_W+4:TAG_W+1];
      else       status_flags_r <= status_flags_r;
      ovf_trap_r <= trap_s;
      if (trap_s) ovf_count_r <= sat_inc(ovf_count_r);
      else        ovf_count_r <= ovf_count_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = head_valid_r;
  assign out_r        = head_r[E_W-1:TAG_W+5];
  assign out_flags    = head_r[TAG_W+4:TAG_W+1];
  assign out_rd       = head_r[TAG_W:1];
  assign out_we       = head_r[0];
  assign status_flags = status_flags_r;
  assign ovf_trap     = ovf_trap_r;
  assign ovf_count    = ovf_count_r;
  assign occupancy    = occupancy_r;

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed self-checking bench for alu_result_skid.
module tb_alu_result_skid;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_r;
  logic        in_zero, in_carry, in_negative, in_overflow;
  logic [4:0]  in_rd;
  logic        in_we, in_trap_en, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_r;
  logic [3:0]  out_flags;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [3:0]  status_flags;
  logic        ovf_trap;
  logic [15:0] ovf_count;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  alu_result_skid dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_zero(in_zero), .in_carry(in_carry),
    .in_negative(in_negative), .in_overflow(in_overflow), .in_rd(in_rd),
    .in_we(in_we), .in_trap_en(in_trap_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_flags(out_flags), .out_rd(out_rd), .out_we(out_we),
    .status_flags(status_flags), .ovf_trap(ovf_trap),
    .ovf_count(ovf_count), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                       input logic [4:0] rd, input logic we, input logic te);
    in_valid = v; in_r = r; {in_zero, in_carry, in_negative, in_overflow} = f;
    in_rd = rd; in_we = we; in_trap_en = te;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({out_valid, out_r, out_flags, out_rd, out_we} !== 42'd0) begin errors++; $display("FAIL reset_out got %b/%h/%b/%0d/%b exp all 0", out_valid, out_r, out_flags, out_rd, out_we); end
    checks++; if ({status_flags, ovf_trap, ovf_count, occupancy} !== 23'd0) begin errors++; $display("FAIL reset_status got %b/%b/%h/%0d exp all 0", status_flags, ovf_trap, ovf_count, occupancy); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 4'b0000, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    checks++; if ({out_valid, out_r, out_rd, out_we} !== {1'b1, 32'h5, 5'd3, 1'b1}) begin errors++; $display("FAIL pass_out got v=%b r=%h rd=%0d we=%b exp 1/5/3/1", out_valid, out_r, out_rd, out_we); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL pass_occ1 got %0d exp 1", occupancy); end
    step();
    checks++; if (status_flags !== 4'b0000 || occupancy !== 2'd0) begin errors++; $display("FAIL pass_drain got sf=%b occ=%0d exp 0000/0", status_flags, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 4'b1000, 5'd1, 1'b1, 1'b0);
    step();
    checks++; if (out_r !== 32'hAAAA_0001 || in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_a got r=%h rdy=%b occ=%0d exp AAAA0001/1/1", out_r, in_ready, occupancy); end
    drive(1'b1, 32'hBBBB_0002, 4'b0100, 5'd2, 1'b1, 1'b0);
    step();
    checks++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin errors++; $display("FAIL bp_full got rdy=%b occ=%0d exp 0/2", in_ready, occupancy); end
    drive(1'b1, 32'hCCCC_0003, 4'b0010, 5'd4, 1'b1, 1'b0);
    step();
    checks++; if (out_r !== 32'hAAAA_0001 || out_rd !== 5'd1 || in_ready !== 1'b0 || occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold got r=%h rd=%0d rdy=%b occ=%0d exp AAAA0001/1/0/2", out_r, out_rd, in_ready, occupancy); end
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    checks++; if (out_r !== 32'hBBBB_0002 || out_rd !== 5'd2 || in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_pop_a got r=%h rd=%0d rdy=%b occ=%0d exp BBBB0002/2/1/1", out_r, out_rd, in_ready, occupancy); end
    checks++; if (status_flags !== 4'b1000) begin errors++; $display("FAIL bp_sf_a got %b exp 1000", status_flags); end
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || status_flags !== 4'b0100) begin errors++; $display("FAIL bp_pop_b got v=%b occ=%0d sf=%b exp 0/0/0100", out_valid, occupancy, status_flags); end
  endtask

  task automatic test_signed_overflow();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 4'b0011, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    checks++; if (out_we !== 1'b0 || out_flags !== 4'b0011 || out_r !== 32'h8000_0000) begin errors++; $display("FAIL trap_out got we=%b fl=%b r=%h exp 0/0011/80000000", out_we, out_flags, out_r); end
    checks++; if (ovf_trap !== 1'b1 || ovf_count !== 16'd1) begin errors++; $display("FAIL trap_pulse got trap=%b cnt=%0d exp 1/1", ovf_trap, ovf_count); end
    step();
    checks++; if (ovf_trap !== 1'b0 || ovf_count !== 16'd1) begin errors++; $display("FAIL trap_one_cycle got trap=%b cnt=%0d exp 0/1", ovf_trap, ovf_count); end
  endtask

  task automatic test_unsigned_ignore();
    drive(1'b1, 32'h8000_0000, 4'b0011, 5'd7, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    checks++; if (out_we !== 1'b1 || ovf_trap !== 1'b0 || ovf_count !== 16'd1) begin errors++; $display("FAIL unsigned got we=%b trap=%b cnt=%0d exp 1/0/1", out_we, ovf_trap, ovf_count); end
    step();
  endtask

  task automatic test_saturation();
    test_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 4'b0011, 5'd9, 1'b1, 1'b1);
    for (int i = 0; i < 65534; i++) step();
    checks++; if (ovf_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp FFFE", ovf_count); end
    step();
    checks++; if (ovf_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp FFFF", ovf_count); end
    step();
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    checks++; if (ovf_count !== 16'hFFFF || ovf_trap !== 1'b1) begin errors++; $display("FAIL sat_hold got cnt=%h trap=%b exp FFFF/1", ovf_count, ovf_trap); end
    step();
  endtask

  task automatic test_flush();
    test_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 4'b0100, 5'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h2222_2222, 4'b0000, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h3333_3333, 4'b0001, 5'd3, 1'b1, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_trap !== 1'b0) begin errors++; $display("FAIL flush_full got occ=%0d v=%b rdy=%b trap=%b exp 0/0/1/0", occupancy, out_valid, in_ready, ovf_trap); end
    checks++; if (status_flags !== 4'b0100) begin errors++; $display("FAIL flush_sf got %b exp 0100", status_flags); end
    // Head-only state: the flush cycle offers a trapping entry that must vanish.
    drive(1'b1, 32'h4444_4444, 4'b0000, 5'd4, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h8000_0000, 4'b0011, 5'd5, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || ovf_trap !== 1'b0 || ovf_count !== 16'd0) begin errors++; $display("FAIL flush_accept got occ=%0d v=%b trap=%b cnt=%0d exp 0/0/0/0", occupancy, out_valid, ovf_trap, ovf_count); end
    step();
    checks++; if (ovf_trap !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got trap=%b v=%b exp 0/0", ovf_trap, out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 4'b0011, 5'd6, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'h5555_5555, 4'b1000, 5'd8, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 4'b0000, 5'd0, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2 || ovf_count !== 16'd1) begin errors++; $display("FAIL rst_pre got occ=%0d cnt=%0d exp 2/1", occupancy, ovf_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_r, out_flags, out_rd, out_we, occupancy, ovf_count, ovf_trap} !== 61'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_async got v=%b r=%h occ=%0d cnt=%0d trap=%b rdy=%b exp 0/0/0/0/0/1", out_valid, out_r, occupancy, ovf_count, ovf_trap, in_ready); end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (ovf_trap !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_after got trap=%b v=%b exp 0/0", ovf_trap, out_valid); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_backpressure();
    test_signed_overflow();
    test_unsigned_ignore();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_skid.md
Name: alu_result_skid

Overview:
- Output stage directly downstream of the 32-bit ALU; captures its result word and the zero/carry/negative/overflow flags, plus the destination register tag.
- 2-entry skid buffer with a valid/ready handshake toward writeback; fully registered outputs break the ALU-to-writeback timing path.
- Applies the signed-overflow trap rule: the write is suppressed and a one-cycle trap pulse is raised.
- Keeps a committed status-flag register and a saturating overflow-event counter.

Parameters:
DATA_W, 32, result width (must match ALU r)
TAG_W, 5, destination register index width
CNT_W, 16, overflow counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU result valid this cycle
in_ready  out  1  buffer can accept; registered
in_r  in  DATA_W  ALU result
in_zero  in  1  ALU zero flag
in_carry  in  1  ALU carry flag
in_negative  in  1  ALU negative flag
in_overflow  in  1  ALU overflow flag
in_rd  in  TAG_W  destination register index
in_we  in  1  register write requested
in_trap_en  in  1  op is signed add/sub (overflow traps)
flush  in  1  synchronous discard of all buffered entries
out_valid  out  1  head entry valid
out_ready  in  1  writeback accepts head
out_r  out  DATA_W  head result
out_flags  out  4  head {zero,carry,negative,overflow}
out_rd  out  TAG_W  head destination
out_we  out  1  head write enable, after trap suppression
status_flags  out  4  flags of last entry consumed at output
ovf_trap  out  1  one-cycle pulse, trap accepted
ovf_count  out  CNT_W  accepted trapping overflows, saturating
occupancy  out  2  entries held, 0..2

Behaviour:
- Reset (async assert, sync-free deassert):
  - in_ready=1.
  - out_valid=0; out_r, out_flags, out_rd, out_we = 0.
  - status_flags=0, ovf_trap=0, ovf_count=0, occupancy=0.
- Storage:
  - head register (drives out_*) and skid register.
  - in_ready = NOT skid_valid, taken from the register; it never depends combinationally on out_ready.
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Latency: an accepted entry appears on out_* the next cycle if the head was empty or is popped in the same cycle; otherwise it goes to skid.
- Transitions (E=empty, H=head only, F=head+skid):
  - E: accept -> H.
  - H: accept only -> F (data to skid); pop only -> E; accept+pop -> H, head loaded with the new entry.
  - F: in_ready=0, no accept possible; pop -> H, skid moves to head, skid cleared.
- Trap rule, evaluated at accept:
  - If in_trap_en & in_overflow, the stored we=0; ovf_trap=1 for exactly the next cycle.
  - ovf_count increments by 1 and saturates at all-ones.
  - Stored flags and r are kept unchanged so the exception handler can inspect them.
- Non-trapping ops (in_trap_en=0) never suppress we, whatever in_overflow is; unsigned ALU ops report overflow=0 anyway.
- status_flags updates on pop with the popped entry's flags; otherwise it holds.
- flush:
  - Next cycle: E, out_valid=0, in_ready=1, occupancy=0.
  - An accept in the flush cycle is discarded: no trap pulse, no count.
  - A pop in the flush cycle still updates status_flags.
  - ovf_count is not cleared.
- occupancy = head_valid + skid_valid, registered with the state.
- out_* hold stable while out_valid & !out_ready.
- in_* are sampled only at accept; values while not accepted are ignored, including X.
- Reset mid-operation: all entries dropped immediately; no pulse is generated.

Test Plan:
- Passthrough: out_ready=1; accept r=32'h0000_0005, rd=3, we=1, flags 4'b0000 -> next cycle out_valid=1, out_r=5, out_rd=3, out_we=1, occupancy=1; a cycle later status_flags=0, occupancy=0.
- Backpressure: out_ready=0; send 3 back-to-back valid entries A,B,C -> A at head, B in skid, in_ready=0 from cycle 3, C not accepted, occupancy=2; raise out_ready -> A then B emitted in order, in_ready=1 the cycle after A pops.
- Signed overflow: accept r=32'h8000_0000, in_overflow=1, in_trap_en=1, we=1 -> out_we=0, out_flags=4'b0011, ovf_trap high exactly 1 cycle, ovf_count=1.
- Unsigned ignore: same r with in_overflow=1, in_trap_en=0 -> out_we=1, ovf_trap=0, ovf_count unchanged.
- Saturation: preload 65535 trapping accepts, send one more -> ovf_count stays 16'hFFFF.
- Flush/reset: state F, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, no trap pulse; separately, pull rst_n low mid-stream -> all outputs 0 asynchronously, before the next clk edge.
